// File: rtl/lfsr_rr_scheduler.sv
// Round-robin front end for one shared XNOR LFSR. It seeds the LFSR, steps it STEPS times
// per granted request, and returns one word together with a single-cycle grant.
module lfsr_rr_scheduler #(
    parameter int NUM_BITS = 32,
    parameter int NUM_REQ  = 4,
    parameter int STEPS    = NUM_BITS
) (
    input  logic                i_Clk,
    input  logic                i_Rst,
    input  logic [NUM_REQ-1:0]  i_Req,
    output logic [NUM_REQ-1:0]  o_Gnt,
    output logic [NUM_BITS-1:0] o_Data,
    output logic                o_Wrap,
    output logic                o_Busy,
    input  logic                i_Seed_DV,
    input  logic [NUM_BITS-1:0] i_Seed_Data,
    output logic                o_Seed_Err,
    output logic                o_LFSR_Enable,
    output logic                o_LFSR_Seed_DV,
    output logic [NUM_BITS-1:0] o_LFSR_Seed_Data,
    input  logic [NUM_BITS-1:0] i_LFSR_Data,
    input  logic                i_LFSR_Done
);

    localparam int         PTR_W     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [7:0] LAST_STEP = 8'(STEPS - 1);

    typedef enum logic [1:0] {SEED, IDLE, STEP, GRANT} state_t;

    state_t              state;
    logic [NUM_BITS-1:0] seed_q;
    logic [NUM_BITS-1:0] pend_seed;
    logic                pend_q;
    logic [PTR_W-1:0]    rr_ptr;
    logic [PTR_W-1:0]    winner;
    logic [7:0]          step_cnt;

    logic [PTR_W-1:0]    pick;
    logic [PTR_W-1:0]    pick_next;
    logic                pick_found;
    logic [NUM_REQ-1:0]  req_sh;
    int                  idx;
    logic                seed_ok;
    logic                seed_bad;

    // An all-ones seed is the XNOR lock-up state and is never accepted.
    assign seed_bad = i_Seed_DV && (i_Seed_Data == '1);
    assign seed_ok  = i_Seed_DV && (i_Seed_Data != '1);

    // NOTE: every variable gets a default before the loop so no latch is inferred.
    always_comb begin
        pick       = '0;
        pick_found = 1'b0;
        idx        = 0;
        req_sh     = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx    = (int'(rr_ptr) + i) % NUM_REQ;
            req_sh = i_Req >> idx;
            if (!pick_found && req_sh[0]) begin
                pick       = PTR_W'(idx);
                pick_found = 1'b1;
            end
        end
    end

    assign pick_next = (pick == PTR_W'(NUM_REQ - 1)) ? '0 : pick + 1'b1;

    // NOTE: every state register is cleared by the synchronous reset; holding
    // reset keeps the FSM in SEED, so the LFSR is continuously reloaded with 0.
    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            state      <= SEED;
            seed_q     <= '0;
            pend_seed  <= '0;
            pend_q     <= 1'b0;
            rr_ptr     <= '0;
            winner     <= '0;
            step_cnt   <= '0;
            o_Seed_Err <= 1'b0;
        end else begin
            o_Seed_Err <= seed_bad;

            // A seed arriving mid-service is parked; a newer one overwrites it.
            if (seed_ok && state != IDLE) begin
                pend_seed <= i_Seed_Data;
                pend_q    <= 1'b1;
            end

            unique case (state)
                SEED: state <= IDLE;
                IDLE: begin
                    if (pend_q || seed_ok) begin
                        seed_q <= seed_ok ? i_Seed_Data : pend_seed;
                        pend_q <= 1'b0;
                        state  <= SEED;
                    end else if (pick_found) begin
                        winner   <= pick;
                        rr_ptr   <= pick_next;
                        step_cnt <= '0;
                        state    <= STEP;
                    end
                end
                STEP: begin
                    step_cnt <= step_cnt + 8'd1;
                    if (step_cnt == LAST_STEP) state <= GRANT;
                end
                GRANT: state <= IDLE;
                default: state <= SEED;
            endcase
        end
    end

    assign o_Busy           = (state != IDLE);
    assign o_LFSR_Enable    = (state == SEED) || (state == STEP);
    assign o_LFSR_Seed_DV   = (state == SEED);
    assign o_LFSR_Seed_Data = seed_q;
    assign o_Gnt            = (state == GRANT) ? (NUM_REQ'(1) << winner) : '0;
    assign o_Data           = (state == GRANT) ? i_LFSR_Data : '0;
    assign o_Wrap           = (state == GRANT) && i_LFSR_Done;

endmodule

// File: tb/tb_lfsr_rr_scheduler.sv
// Bench for lfsr_rr_scheduler: two instances (STEPS=1 and STEPS=4), each beside a small
// behavioural XNOR LFSR, checked against a sequence-position / round-robin reference model.
module tb_lfsr_rr_scheduler;

    localparam int NB      = 4;
    localparam int NR      = 4;
    localparam int STEPS_A = 1;
    localparam int STEPS_B = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    // 4-bit XNOR LFSR with taps 4,3: shift left, feedback into bit 0.
    function automatic logic [NB-1:0] lfsr_next(input logic [NB-1:0] v);
        return {v[NB-2:0], ~(v[3] ^ v[2])};
    endfunction

    function automatic logic [NB-1:0] advance(input logic [NB-1:0] v, input int n);
        logic [NB-1:0] r;
        r = v;
        for (int i = 0; i < n; i++) r = lfsr_next(r);
        return r;
    endfunction

    function automatic int rr_pick(input logic [NR-1:0] mask, input int last);
        for (int k = 1; k <= NR; k++)
            if (mask[(last + k) % NR]) return (last + k) % NR;
        return 0;
    endfunction

    // Instance A: STEPS = 1
    logic          a_rst = 1'b1, a_sdv = 1'b0, a_done;
    logic [NR-1:0] a_req = '0, a_gnt;
    logic [NB-1:0] a_sdata = '0, a_data, a_lsdata, a_lfsr = '0;
    logic          a_wrap, a_busy, a_err, a_en, a_lsdv;

    lfsr_rr_scheduler #(.NUM_BITS(NB), .NUM_REQ(NR), .STEPS(STEPS_A)) dut_a (
        .i_Clk(clk), .i_Rst(a_rst), .i_Req(a_req), .o_Gnt(a_gnt), .o_Data(a_data),
        .o_Wrap(a_wrap), .o_Busy(a_busy), .i_Seed_DV(a_sdv), .i_Seed_Data(a_sdata),
        .o_Seed_Err(a_err), .o_LFSR_Enable(a_en), .o_LFSR_Seed_DV(a_lsdv),
        .o_LFSR_Seed_Data(a_lsdata), .i_LFSR_Data(a_lfsr), .i_LFSR_Done(a_done));

    always @(posedge clk) if (a_en === 1'b1) a_lfsr <= (a_lsdv ? a_lsdata : lfsr_next(a_lfsr));
    assign a_done = (a_lfsr == a_lsdata);

    // Instance B: STEPS = 4
    logic          b_rst = 1'b1, b_sdv = 1'b0, b_done;
    logic [NR-1:0] b_req = '0, b_gnt;
    logic [NB-1:0] b_sdata = '0, b_data, b_lsdata, b_lfsr = '0;
    logic          b_wrap, b_busy, b_err, b_en, b_lsdv;

    lfsr_rr_scheduler #(.NUM_BITS(NB), .NUM_REQ(NR), .STEPS(STEPS_B)) dut_b (
        .i_Clk(clk), .i_Rst(b_rst), .i_Req(b_req), .o_Gnt(b_gnt), .o_Data(b_data),
        .o_Wrap(b_wrap), .o_Busy(b_busy), .i_Seed_DV(b_sdv), .i_Seed_Data(b_sdata),
        .o_Seed_Err(b_err), .o_LFSR_Enable(b_en), .o_LFSR_Seed_DV(b_lsdv),
        .o_LFSR_Seed_Data(b_lsdata), .i_LFSR_Data(b_lfsr), .i_LFSR_Done(b_done));

    always @(posedge clk) if (b_en === 1'b1) b_lfsr <= (b_lsdv ? b_lsdata : lfsr_next(b_lfsr));
    assign b_done = (b_lfsr == b_lsdata);

    // Reference model for instance A: sequence position, active seed, last winner.
    logic [NB-1:0] ma_lfsr = '0;
    logic [NB-1:0] ma_seed = '0;
    int            ma_last = NR - 1;
    int            last_gnt_cyc = 0;

    task automatic model_reset_a();
        ma_lfsr = '0;
        ma_seed = '0;
        ma_last = NR - 1;
    endtask

    task automatic reset_a();
        a_rst = 1'b1;
        a_req = '0;
        a_sdv = 1'b0;
        @(negedge clk);
        @(negedge clk);
        a_rst = 1'b0;
        model_reset_a();
        @(negedge clk);
    endtask

    task automatic reset_b();
        b_rst = 1'b1;
        b_req = '0;
        @(negedge clk);
        @(negedge clk);
        b_rst = 1'b0;
        @(negedge clk);
    endtask

    // Waits (bounded) for the next grant of instance A and checks it against the model.
    task automatic a_serve(input string name, input logic [NR-1:0] mask, output logic [NR-1:0] got);
        int            w;
        int            n;
        logic [NR-1:0] exp_gnt;
        logic          exp_wrap;
        w        = rr_pick(mask, ma_last);
        ma_last  = w;
        ma_lfsr  = advance(ma_lfsr, STEPS_A);
        exp_wrap = (ma_lfsr == ma_seed);
        exp_gnt  = '0;
        exp_gnt[w] = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (a_gnt === '0 && n < 40);
        got          = a_gnt;
        last_gnt_cyc = cyc;
        checks++;
        if (a_gnt !== exp_gnt) begin
            errors++;
            $display("FAIL %s gnt: got %b want %b", name, a_gnt, exp_gnt);
        end
        checks++;
        if (a_data !== ma_lfsr) begin
            errors++;
            $display("FAIL %s data: got %h want %h", name, a_data, ma_lfsr);
        end
        checks++;
        if (a_wrap !== exp_wrap) begin
            errors++;
            $display("FAIL %s wrap: got %b want %b", name, a_wrap, exp_wrap);
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (a_gnt !== '0 || a_data !== '0 || a_wrap !== 1'b0 || a_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: gnt %b data %h wrap %b err %b want 0000 0 0 0",
                     a_gnt, a_data, a_wrap, a_err);
        end
        checks++;
        if (a_busy !== 1'b1 || a_en !== 1'b1 || a_lsdv !== 1'b1 || a_lsdata !== '0) begin
            errors++;
            $display("FAIL reset_lfsr_ctl: busy %b en %b sdv %b sdata %h want 1 1 1 0",
                     a_busy, a_en, a_lsdv, a_lsdata);
        end
        a_rst = 1'b0;
        model_reset_a();
        @(negedge clk);
        checks++;
        if (a_busy !== 1'b0 || a_en !== 1'b0 || a_lsdv !== 1'b0) begin
            errors++;
            $display("FAIL reset_to_idle: busy %b en %b sdv %b want 0 0 0", a_busy, a_en, a_lsdv);
        end
    endtask

    task automatic test_sequence();
        logic [NB-1:0] tbl [15];
        logic [NR-1:0] g;
        int            prev;
        tbl = '{4'h1, 4'h3, 4'h7, 4'hE, 4'hD, 4'hB, 4'h6, 4'hC,
                4'h9, 4'h2, 4'h5, 4'hA, 4'h4, 4'h8, 4'h0};
        prev  = 0;
        a_req = 4'b0001;
        for (int i = 0; i < 15; i++) begin
            a_serve("sequence", 4'b0001, g);
            checks++;
            if (a_data !== tbl[i] || a_wrap !== (i == 14)) begin
                errors++;
                $display("FAIL sequence_table[%0d]: data %h wrap %b want %h %b",
                         i, a_data, a_wrap, tbl[i], (i == 14));
            end
            if (i > 0) begin
                checks++;
                if (last_gnt_cyc - prev !== STEPS_A + 2) begin
                    errors++;
                    $display("FAIL sequence_spacing[%0d]: got %0d want %0d",
                             i, last_gnt_cyc - prev, STEPS_A + 2);
                end
            end
            prev = last_gnt_cyc;
        end
        a_req = '0;
    endtask

    task automatic test_round_robin();
        int            order [10];
        logic [NR-1:0] g;
        logic [NR-1:0] mask;
        order = '{0, 1, 2, 3, 0, 1, 2, 3, 0, 2};
        reset_a();
        mask  = 4'b1111;
        a_req = mask;
        for (int i = 0; i < 10; i++) begin
            if (i == 6) begin
                mask  = 4'b1101;
                a_req = mask;
            end
            a_serve("round_robin", mask, g);
            checks++;
            if (g !== (NR'(1) << order[i])) begin
                errors++;
                $display("FAIL round_robin_order[%0d]: got %b want requester %0d", i, g, order[i]);
            end
            if (i == 5) a_req = 4'b1101;
        end
        a_req = '0;
    endtask

    task automatic test_seed_during_step();
        logic [NR-1:0] g;
        @(negedge clk);
        a_req = 4'b0001;
        @(negedge clk);
        checks++;
        if (a_busy !== 1'b1 || a_en !== 1'b1 || a_lsdv !== 1'b0) begin
            errors++;
            $display("FAIL step_ctl: busy %b en %b sdv %b want 1 1 0", a_busy, a_en, a_lsdv);
        end
        a_sdv   = 1'b1;
        a_sdata = 4'h5;
        @(negedge clk);
        a_sdv   = 1'b0;
        ma_lfsr = advance(ma_lfsr, STEPS_A);
        ma_last = 0;
        checks++;
        if (a_gnt !== 4'b0001 || a_data !== ma_lfsr) begin
            errors++;
            $display("FAIL seed_mid_step_grant: gnt %b data %h want 0001 %h", a_gnt, a_data, ma_lfsr);
        end
        a_req = '0;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (a_lsdv !== 1'b1 || a_lsdata !== 4'h5) begin
            errors++;
            $display("FAIL seed_pending_load: sdv %b sdata %h want 1 5", a_lsdv, a_lsdata);
        end
        ma_seed = 4'h5;
        ma_lfsr = 4'h5;
        @(negedge clk);
        checks++;
        if (a_busy !== 1'b0 || a_lfsr !== 4'h5) begin
            errors++;
            $display("FAIL seed_pending_idle: busy %b lfsr %h want 0 5", a_busy, a_lfsr);
        end
        a_req = 4'b0001;
        a_serve("seed_next_word", 4'b0001, g);
        checks++;
        if (a_data !== 4'hA) begin
            errors++;
            $display("FAIL seed_next_word_const: got %h want a", a_data);
        end
        a_req = '0;
    endtask

    task automatic test_seed_err();
        logic [NR-1:0] g;
        logic [NB-1:0] seed_before;
        @(negedge clk);
        seed_before = a_lsdata;
        a_sdv   = 1'b1;
        a_sdata = 4'hF;
        @(negedge clk);
        a_sdv = 1'b0;
        checks++;
        if (a_err !== 1'b1 || a_busy !== 1'b0 || a_lsdata !== seed_before) begin
            errors++;
            $display("FAIL seed_err_idle: err %b busy %b sdata %h want 1 0 %h",
                     a_err, a_busy, a_lsdata, seed_before);
        end
        @(negedge clk);
        checks++;
        if (a_err !== 1'b0) begin
            errors++;
            $display("FAIL seed_err_one_cycle: got %b want 0", a_err);
        end
        a_req = 4'b0001;
        @(negedge clk);
        a_sdv   = 1'b1;
        a_sdata = 4'hF;
        @(negedge clk);
        a_sdv   = 1'b0;
        ma_lfsr = advance(ma_lfsr, STEPS_A);
        ma_last = 0;
        checks++;
        if (a_err !== 1'b1 || a_gnt !== 4'b0001 || a_data !== ma_lfsr) begin
            errors++;
            $display("FAIL seed_err_step: err %b gnt %b data %h want 1 0001 %h",
                     a_err, a_gnt, a_data, ma_lfsr);
        end
        a_req = '0;
        @(negedge clk);
        checks++;
        if (a_busy !== 1'b0 || a_err !== 1'b0) begin
            errors++;
            $display("FAIL seed_err_no_reload: busy %b err %b want 0 0", a_busy, a_err);
        end
        a_req = 4'b0001;
        a_serve("seed_err_continue", 4'b0001, g);
        a_req = '0;
    endtask

    task automatic test_random();
        logic [NR-1:0] mask;
        logic [NR-1:0] g;
        logic [NB-1:0] s;
        reset_a();
        mask = NR'($urandom_range(1, 15));
        a_req = mask;
        for (int i = 0; i < 40; i++) begin
            a_serve("random", mask, g);
            mask = (mask & ~g) | NR'($urandom_range(0, 15));
            if (mask == '0) mask = NR'(1) << $urandom_range(0, NR - 1);
            a_req = mask;
            if ($urandom_range(0, 3) == 0) begin
                s       = NB'($urandom_range(0, 15));
                if (i % 8 == 3) s = 4'hF;
                a_sdv   = 1'b1;
                a_sdata = s;
                @(negedge clk);
                a_sdv = 1'b0;
                checks++;
                if (a_err !== (s == 4'hF)) begin
                    errors++;
                    $display("FAIL random_seed_err: seed %h err %b want %b", s, a_err, (s == 4'hF));
                end
                if (s != 4'hF) begin
                    ma_seed = s;
                    ma_lfsr = s;
                end
            end
        end
        a_req = '0;
    endtask

    // Instance B: request sampled in IDLE at t, grant exactly at t+STEPS+1.
    task automatic b_timed_grant(input string name);
        b_req = 4'b0100;
        for (int k = 1; k <= STEPS_B; k++) begin
            @(negedge clk);
            checks++;
            if (b_gnt !== '0 || b_busy !== 1'b1) begin
                errors++;
                $display("FAIL %s step%0d: gnt %b busy %b want 0000 1", name, k, b_gnt, b_busy);
            end
        end
        @(negedge clk);
        b_req = '0;
        checks++;
        if (b_gnt !== 4'b0100 || b_data !== 4'hE || b_wrap !== 1'b0) begin
            errors++;
            $display("FAIL %s grant: gnt %b data %h wrap %b want 0100 e 0", name, b_gnt, b_data, b_wrap);
        end
        @(negedge clk);
        checks++;
        if (b_busy !== 1'b0 || b_gnt !== '0 || b_data !== '0) begin
            errors++;
            $display("FAIL %s after: busy %b gnt %b data %h want 0 0000 0", name, b_busy, b_gnt, b_data);
        end
    endtask

    task automatic test_latency();
        reset_b();
        b_timed_grant("latency");
    endtask

    task automatic test_reset_mid_step();
        int seen;
        b_req = 4'b0100;
        @(negedge clk);
        @(negedge clk);
        b_rst = 1'b1;
        b_req = '0;
        @(negedge clk);
        checks++;
        if (b_gnt !== '0 || b_busy !== 1'b1 || b_lsdv !== 1'b1 || b_lsdata !== '0) begin
            errors++;
            $display("FAIL reset_mid_step: gnt %b busy %b sdv %b sdata %h want 0000 1 1 0",
                     b_gnt, b_busy, b_lsdv, b_lsdata);
        end
        b_rst = 1'b0;
        @(negedge clk);
        checks++;
        if (b_lfsr !== '0 || b_busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_step_reload: lfsr %h busy %b want 0 0", b_lfsr, b_busy);
        end
        seen = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (b_gnt !== '0) seen++;
        end
        checks++;
        if (seen != 0) begin
            errors++;
            $display("FAIL reset_mid_step_no_grant: got %0d grants want 0", seen);
        end
        b_timed_grant("after_reset");
    endtask

    initial begin
        test_reset();
        test_sequence();
        test_round_robin();
        test_seed_during_step();
        test_seed_err();
        test_random();
        test_latency();
        test_reset_mid_step();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
